hq2x_blend_sequencer: RTL

Producer side of the 2x-upscaler blend datapath. Accepts one 3x3 neighbourhood of 15-bit RGB555 pixels and classifies it by per-channel similarity. For each of the four output sub-pixels it issues one blend command (9-bit op plus A/B/C colour operands) to the downstream channel blender. Uses valid/ready handshakes on both sides and sits between the line-buffer window and the blend/writeback stage.

---
 rtl/hq2x_blend_sequencer_pkg.sv | 18 +
 rtl/hq2x_blend_sequencer_if.sv | 13 +
 rtl/hq2x_blend_sequencer_pix_similar.sv | 13 +
 rtl/hq2x_blend_sequencer.sv | 70 +++++++
 4 files changed

// File: rtl/hq2x_blend_sequencer_pkg.sv
// hq2x_pkg: shared state enum, blend op codes, per-quadrant H/V/D pixel indices and the rule-priority op picker
package hq2x_pkg;
  localparam int PW = 15;
  typedef enum logic [1:0] {IDLE, CLASSIFY, EMIT} state_t;
  localparam logic [8:0] OP_PASS   = 9'h100;
  localparam logic [8:0] OP_EDGE   = 9'h08A;
  localparam logic [8:0] OP_CORNER = 9'h0F0;
  localparam logic [8:0] OP_SOFT   = 9'h0C5;
  localparam logic [3:0] QH [4] = '{4'd3, 4'd5, 4'd3, 4'd5};
  localparam logic [3:0] QV [4] = '{4'd1, 4'd1, 4'd7, 4'd7};
  localparam logic [3:0] QD [4] = '{4'd0, 4'd2, 4'd6, 4'd8};
  function automatic logic [2:0] nb_idx(input logic [3:0] p);
    return p > 4'd4 ? 3'(p - 4'd1) : p[2:0];
  endfunction
  function automatic logic [8:0] blend_op(input logic h, v, d, hv);
    return h && v && d ? OP_PASS : !h && !v && hv ? OP_EDGE : h && v ? OP_CORNER : OP_SOFT;
  endfunction
endpackage

// File: rtl/hq2x_blend_sequencer_if.sv
// hq2x_blend_sequencer_if: neighbourhood in (valid/ready/pix) and blend command out (valid/ready/op/a/b/c/quad/last)
interface hq2x_blend_sequencer_if;
  import hq2x_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [9*PW-1:0] in_pix;
  logic [8:0] out_op;
  logic [PW-1:0] out_a, out_b, out_c;
  logic [1:0] out_quad;
  modport master(output in_valid, in_pix, out_ready,
                 input in_ready, out_valid, out_op, out_a, out_b, out_c, out_quad, out_last);
  modport slave(input in_valid, in_pix, out_ready,
                output in_ready, out_valid, out_op, out_a, out_b, out_c, out_quad, out_last);
endinterface

// File: rtl/hq2x_blend_sequencer_pix_similar.sv
// pix_similar: a,b RGB555 in, sim out high when every channel differs by at most THRESH
module pix_similar import hq2x_pkg::*; #(parameter int THRESH = 3) (
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  output logic          sim
);
  function automatic logic close(input logic [4:0] x, y);
    logic signed [5:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    return (d[5] ? -d : d) <= 6'(THRESH);
  endfunction
  assign sim = close(a[14:10], b[14:10]) && close(a[9:5], b[9:5]) && close(a[4:0], b[4:0]);
endmodule

// File: rtl/hq2x_blend_sequencer.sv
// hq2x_blend_sequencer: clk, reset, bus.slave; takes a 3x3 window and issues four registered blend commands (quad 0..3)
module hq2x_blend_sequencer import hq2x_pkg::*; #(parameter int THRESH = 3) (
  input logic                clk,
  input logic                reset,
  hq2x_blend_sequencer_if.slave bus
);
  state_t state;
  logic [PW-1:0] px [9];
  logic [7:0] sim_c, sim_r, se;
  logic [3:0] hv_c, hv_r, sh;
  logic [1:0] nq;
  logic [8:0] nop;
  logic [PW-1:0] nb, nc;
  for (genvar n = 0; n < 8; n++) begin : g_nb
    pix_similar #(.THRESH(THRESH)) u_sim (.a(px[n < 4 ? n : n + 1]), .b(px[4]), .sim(sim_c[n]));
  end
  for (genvar q = 0; q < 4; q++) begin : g_hv
    pix_similar #(.THRESH(THRESH)) u_sim (.a(px[QH[q]]), .b(px[QV[q]]), .sim(hv_c[q]));
  end
  // CLASSIFY loads quad 0 straight from the live compare so out_valid lands two cycles after accept
  always_comb begin
    nq = state == CLASSIFY ? 2'd0 : bus.out_quad + 2'd1;
    se = state == CLASSIFY ? sim_c : sim_r;
    sh = state == CLASSIFY ? hv_c : hv_r;
    nop = blend_op(se[nb_idx(QH[nq])], se[nb_idx(QV[nq])], se[nb_idx(QD[nq])], sh[nq]);
    nb = nop == OP_PASS ? '0 : px[QH[nq]];
    nc = nop == OP_PASS ? '0 : px[QV[nq]];
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_op <= '0;
      bus.out_a <= '0;
      bus.out_b <= '0;
      bus.out_c <= '0;
      bus.out_quad <= '0;
      bus.out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          for (int k = 0; k < 9; k++) px[k] <= bus.in_pix[PW*k +: PW];
          bus.in_ready <= 1'b0;
          state <= CLASSIFY;
        end
        CLASSIFY: begin
          sim_r <= sim_c;
          hv_r <= hv_c;
          bus.out_valid <= 1'b1;
          state <= EMIT;
        end
        EMIT: if (bus.out_ready && bus.out_quad == 2'd3) begin
          bus.out_valid <= 1'b0;
          bus.out_last <= 1'b0;
          bus.in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (state == CLASSIFY || (state == EMIT && bus.out_ready && bus.out_quad != 2'd3)) begin
        bus.out_op <= nop;
        bus.out_a <= px[4];
        bus.out_b <= nb;
        bus.out_c <= nc;
        bus.out_quad <= nq;
        bus.out_last <= nq == 2'd3;
      end
    end
endmodule
